// File: rtl/ps2_mouse_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_rx
// Purpose  : Receive-only PS/2 mouse front end. Conditions the raw PS/2
//            clock/data lines, decodes 11-bit device frames, assembles
//            3-byte stream-mode packets and maintains a clamped absolute
//            cursor position plus button state.
// Ports    : clk, rst          - system clock, async active-high reset
//            ps2_clk_i          - raw PS/2 clock line level
//            ps2_data_i         - raw PS/2 data line level
//            mouse_x/mouse_y    - cursor position, 0..X_MAX / 0..Y_MAX
//            mouse_click        - {5'b0, middle, right, left}
//            pkt_valid          - one-cycle pulse with each position update
//            err_cnt            - saturating framing/parity/timeout/sync errors
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [15:0] mouse_x,
    output logic [15:0] mouse_y,
    output logic [7:0]  mouse_click,
    output logic        pkt_valid,
    output logic [7:0]  err_cnt
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic signed [17:0] c_x_lim = 18'(X_MAX);
    localparam logic signed [17:0] c_y_lim = 18'(Y_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic          r_clk_meta, r_clk_sync;
    logic          r_data_meta, r_data_sync;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
        end
    end

    // The filtered clock follows the synchronised clock only once the new
    // level has persisted for FILTER_LEN consecutive cycles; any bounce
    // back to the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_sync == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_sample = r_filt_d & ~r_filt;

    // ------------------------------------------------------------------
    // Bit-level frame decoder
    // ------------------------------------------------------------------
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          w_byte_ok, w_frame_err;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_to_cnt;
    logic          w_to_active, w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_IDLE:   if (!r_data_sync) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    // Good frame: stop bit high and odd parity over data+parity.
                    if (r_data_sync && (^{r_shift, r_parity}))
                        w_byte_ok = 1'b1;
                    else
                        w_frame_err = 1'b1;
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                ST_IDLE:   r_bit_cnt <= '0;
                ST_DATA: begin
                    r_shift   <= {r_data_sync, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_PARITY: r_parity <= r_data_sync;
                default:   r_parity <= r_parity;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Inactivity timeout: only armed while something is half-received.
    // A sample event in the same cycle takes precedence and clears it.
    // ------------------------------------------------------------------
    assign w_to_active = (r_state != ST_IDLE) || (r_idx != 2'd0);
    assign w_timeout   = w_to_active && !w_sample &&
                         (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_sample || !w_to_active || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Packet assembly and cursor update
    // ------------------------------------------------------------------
    logic [2:0]         r_btn;
    logic               r_sx, r_sy, r_ox, r_oy;
    logic [7:0]         r_dx_byte;
    logic [15:0]        r_x, r_y;
    logic [7:0]         r_click;
    logic               r_pkt_valid;
    logic [7:0]         r_err_cnt;
    logic               w_sync_err, w_err;
    logic signed [17:0] w_dx, w_dy, w_x_sum, w_y_sum;
    logic [15:0]        w_x_new, w_y_new;

    assign w_sync_err = w_byte_ok && (r_idx == 2'd0) && !r_shift[3];
    assign w_err      = w_frame_err || w_timeout || w_sync_err;

    // Byte 2 is still in the shift register on its strobe cycle, so the
    // new position is computed from it directly and registered then.
    always_comb begin
        w_dx    = r_ox ? 18'sd0 : {{10{r_sx}}, r_dx_byte};
        w_dy    = r_oy ? 18'sd0 : {{10{r_sy}}, r_shift};
        w_x_sum = $signed({2'b00, r_x}) + w_dx;
        // PS/2 +y points up while screen +y points down.
        w_y_sum = $signed({2'b00, r_y}) - w_dy;
        w_x_new = w_x_sum[15:0];
        w_y_new = w_y_sum[15:0];
        if (w_x_sum[17])
            w_x_new = '0;
        else if (w_x_sum > c_x_lim)
            w_x_new = c_x_lim[15:0];
        if (w_y_sum[17])
            w_y_new = '0;
        else if (w_y_sum > c_y_lim)
            w_y_new = c_y_lim[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= 2'd0;
            r_btn       <= '0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_ox        <= 1'b0;
            r_oy        <= 1'b0;
            r_dx_byte   <= '0;
            r_x         <= 16'(X_MAX / 2);
            r_y         <= 16'(Y_MAX / 2);
            r_click     <= '0;
            r_pkt_valid <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            if (w_timeout || w_frame_err) begin
                r_idx <= 2'd0;
            end else if (w_byte_ok) begin
                case (r_idx)
                    2'd0: begin
                        // Bit 3 of the header is always set; anything else
                        // means we are out of step, so wait for a header.
                        if (r_shift[3]) begin
                            r_btn <= r_shift[2:0];
                            r_sx  <= r_shift[4];
                            r_sy  <= r_shift[5];
                            r_ox  <= r_shift[6];
                            r_oy  <= r_shift[7];
                            r_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_dx_byte <= r_shift;
                        r_idx     <= 2'd2;
                    end
                    2'd2: begin
                        r_x         <= w_x_new;
                        r_y         <= w_y_new;
                        r_click     <= {5'b0, r_btn};
                        r_pkt_valid <= 1'b1;
                        r_idx       <= 2'd0;
                    end
                    default: r_idx <= 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign mouse_x     = r_x;
    assign mouse_y     = r_y;
    assign mouse_click = r_click;
    assign pkt_valid   = r_pkt_valid;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
